// File: rtl/fwd_pkg.sv
// Shared types and constants for the EX-stage forwarding / load-use hazard controller.
package fwd_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  // Destination/control snapshot of one pipeline stage; all-zero is a bubble.
  typedef struct packed {
    logic [REG_AW-1:0] dest;
    logic              rw;
    logic              mr;
    logic              v;
  } stage_shadow_t;

  // A stage can only be a forwarding source if it really writes a non-$0 register.
  function automatic logic writes_reg(input stage_shadow_t s);
    return s.v & s.rw & (s.dest != '0);
  endfunction

endpackage

// File: rtl/fwd_sel_logic.sv
// Combinational forwarding priority compare for one EX operand (EX/MEM beats MEM/WB).
module fwd_sel_logic
  import fwd_pkg::*;
(
  input  logic [REG_AW-1:0] src_i,
  input  stage_shadow_t     ex_i,
  input  stage_shadow_t     mem_i,
  output logic [1:0]        sel_o
);

  always_comb begin
    sel_o = FWD_RF;
    if (writes_reg(ex_i) && (ex_i.dest == src_i)) begin
      sel_o = FWD_EXMEM;
    end else if (writes_reg(mem_i) && (mem_i.dest == src_i)) begin
      sel_o = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Registered forwarding selects and one-cycle load-use stall for a 5-stage MIPS pipeline.
// Optional event counters are built when FWD_HAZARD_STATS_EN is defined.
module fwd_hazard_ctrl
  import fwd_pkg::stage_shadow_t, fwd_pkg::writes_reg, fwd_pkg::FWD_RF, fwd_pkg::FWD_EXMEM,
         fwd_pkg::FWD_MEMWB;
#(
  parameter int REG_AW = 5,
  parameter int SEL_W  = 2
`ifdef FWD_HAZARD_STATS_EN
  ,
  parameter int STAT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              flush,
  output logic [SEL_W-1:0]  fwd_a_sel,
  output logic [SEL_W-1:0]  fwd_b_sel,
  output logic              stall,
  output logic              ex_bubble
`ifdef FWD_HAZARD_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_stalls,
  output logic [STAT_W-1:0] stat_fwd_exmem,
  output logic [STAT_W-1:0] stat_fwd_memwb
`endif
);

  stage_shadow_t     ex_q, ex_d;
  stage_shadow_t     mem_q, mem_d;
  logic [SEL_W-1:0]  fwd_a_q, fwd_a_d;
  logic [SEL_W-1:0]  fwd_b_q, fwd_b_d;
  logic              ex_bubble_q, ex_bubble_d;
  logic              load_use;
  logic              issue;
  logic [REG_AW-1:0] src [2];
  logic [1:0]        sel_raw [2];

  assign src[0] = id_rs;
  assign src[1] = id_rt;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_operand
      fwd_sel_logic u_sel (
        .src_i (src[gi]),
        .ex_i  (ex_q),
        .mem_i (mem_q),
        .sel_o (sel_raw[gi])
      );
    end
  endgenerate

  // The load in EX has no data until MEM, so a consumer in ID must wait one cycle.
  assign load_use = id_valid & writes_reg(ex_q) & ex_q.mr &
                    ((ex_q.dest == id_rs) | (ex_q.dest == id_rt));
  assign stall    = load_use & ~flush & ~rst;
  assign issue    = id_valid & ~flush & ~load_use;

  always_comb begin
    ex_d        = '0;
    mem_d       = ex_q;
    fwd_a_d     = SEL_W'(FWD_RF);
    fwd_b_d     = SEL_W'(FWD_RF);
    ex_bubble_d = 1'b1;
    if (issue) begin
      ex_d        = '{dest: id_dest, rw: id_regwrite, mr: id_memread, v: 1'b1};
      fwd_a_d     = SEL_W'(sel_raw[0]);
      fwd_b_d     = SEL_W'(sel_raw[1]);
      ex_bubble_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      fwd_a_q     <= SEL_W'(FWD_RF);
      fwd_b_q     <= SEL_W'(FWD_RF);
      ex_bubble_q <= 1'b1;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      ex_bubble_q <= ex_bubble_d;
    end
  end

  assign fwd_a_sel = fwd_a_q;
  assign fwd_b_sel = fwd_b_q;
  assign ex_bubble = ex_bubble_q;

`ifdef FWD_HAZARD_STATS_EN
  logic [STAT_W-1:0] stalls_q, stalls_d;
  logic [STAT_W-1:0] exmem_q, exmem_d;
  logic [STAT_W-1:0] memwb_q, memwb_d;
  logic [1:0]        exmem_inc, memwb_inc;

  function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] cnt,
                                                input logic [1:0] inc);
    logic [STAT_W:0] sum;
    sum = {1'b0, cnt} + (STAT_W+1)'(inc);
    return sum[STAT_W] ? '1 : sum[STAT_W-1:0];
  endfunction

  // Each operand is a separate forwarding event, so two can land in one cycle.
  always_comb begin
    exmem_inc = {1'b0, fwd_a_d == SEL_W'(FWD_EXMEM)} + {1'b0, fwd_b_d == SEL_W'(FWD_EXMEM)};
    memwb_inc = {1'b0, fwd_a_d == SEL_W'(FWD_MEMWB)} + {1'b0, fwd_b_d == SEL_W'(FWD_MEMWB)};
    stalls_d  = sat_add(stalls_q, {1'b0, stall});
    exmem_d   = sat_add(exmem_q, exmem_inc);
    memwb_d   = sat_add(memwb_q, memwb_inc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stalls_q <= '0;
      exmem_q  <= '0;
      memwb_q  <= '0;
    end else begin
      stalls_q <= stalls_d;
      exmem_q  <= exmem_d;
      memwb_q  <= memwb_d;
    end
  end

  assign stat_stalls    = stalls_q;
  assign stat_fwd_exmem = exmem_q;
  assign stat_fwd_memwb = memwb_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scoreboard bench for fwd_hazard_ctrl: instruction-level pipeline model vs DUT, directed + random.
module tb_fwd_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, id_dest = '0;
  logic       id_regwrite = 1'b0, id_memread = 1'b0, flush = 1'b0;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       stall, ex_bubble;
`ifdef FWD_HAZARD_STATS_EN
  logic [15:0] stat_stalls, stat_fwd_exmem, stat_fwd_memwb;
`endif

  always #5 clk = ~clk;

  fwd_hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_dest(id_dest), .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall), .ex_bubble(ex_bubble)
`ifdef FWD_HAZARD_STATS_EN
    , .stat_stalls(stat_stalls), .stat_fwd_exmem(stat_fwd_exmem), .stat_fwd_memwb(stat_fwd_memwb)
`endif
  );

  typedef struct { bit v; bit rw; bit mr; int dest; } instr_t;
  typedef struct { bit chk_regs; int a; int b; bit bub; bit stl; int n_st; int n_em; int n_mw; } exp_t;

  instr_t pipe[$];  // instructions in flight: [0] = MEM stage, last = EX stage
  exp_t   sb[$];
  int     checks = 0, failures = 0;
  int     pend_a = 0, pend_b = 0, cyc = 0;
  bit     pend_bub = 1'b1, pend_valid = 1'b0, last_stall = 1'b0;
  int     cnt_st = 0, cnt_em = 0, cnt_mw = 0;

  function automatic int sat(int c, int inc);
    return (c + inc > 65535) ? 65535 : c + inc;
  endfunction

  // Newest in-flight producer of src wins; age 0 is EX/MEM (1), age 1 is MEM/WB (2).
  function automatic int fwd(int src);
    for (int i = pipe.size() - 1; i >= 0; i--)
      if (pipe[i].v && pipe[i].rw && pipe[i].dest != 0 && pipe[i].dest == src)
        return (i == pipe.size() - 1) ? 1 : 2;
    return 0;
  endfunction

  task automatic drive(bit r, bit v, int rs, int rt, int dest, bit rw, bit mr, bit fl);
    exp_t   e;
    instr_t nw, bub;
    bit     lu, iss;
    @(posedge clk); #1;
    rst = r; id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_dest = 5'(dest);
    id_regwrite = rw; id_memread = mr; flush = fl;
    bub = '{v: 1'b0, rw: 1'b0, mr: 1'b0, dest: 0};
    e.chk_regs = pend_valid; e.a = pend_a; e.b = pend_b; e.bub = pend_bub;
    e.n_st = cnt_st; e.n_em = cnt_em; e.n_mw = cnt_mw;
    if (r) begin
      e.stl = 1'b0;
      pipe = {bub, bub};
      pend_a = 0; pend_b = 0; pend_bub = 1'b1; pend_valid = 1'b1;
      cnt_st = 0; cnt_em = 0; cnt_mw = 0;
    end else begin
      nw  = pipe[pipe.size() - 1];
      lu  = v && nw.v && nw.mr && nw.rw && nw.dest != 0 && (nw.dest == rs || nw.dest == rt);
      e.stl = lu && !fl;
      iss = v && !fl && !lu;
      pend_a = iss ? fwd(rs) : 0;
      pend_b = iss ? fwd(rt) : 0;
      pend_bub = !iss;
      cnt_st = sat(cnt_st, e.stl ? 1 : 0);
      cnt_em = sat(cnt_em, (pend_a == 1 ? 1 : 0) + (pend_b == 1 ? 1 : 0));
      cnt_mw = sat(cnt_mw, (pend_a == 2 ? 1 : 0) + (pend_b == 2 ? 1 : 0));
      if (iss) pipe.push_back('{v: 1'b1, rw: rw, mr: mr, dest: dest});
      else     pipe.push_back(bub);
      void'(pipe.pop_front());
    end
    last_stall = e.stl;
    sb.push_back(e);
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", nm, cyc, act, exp);
    end
  endtask

  // Monitor: every cycle the DUT presents stall (this cycle) and registered selects (last edge).
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cyc++;
        $display("cyc %0d rst=%0b v=%0b rs=%0d rt=%0d stall=%0b a=%0d b=%0d bubble=%0b",
                 cyc, rst, id_valid, id_rs, id_rt, stall, fwd_a_sel, fwd_b_sel, ex_bubble);
        chk("stall", 32'(stall), 32'(e.stl));
        if (e.chk_regs) begin
          chk("fwd_a_sel", 32'(fwd_a_sel), 32'(e.a));
          chk("fwd_b_sel", 32'(fwd_b_sel), 32'(e.b));
          chk("ex_bubble", 32'(ex_bubble), 32'(e.bub));
`ifdef FWD_HAZARD_STATS_EN
          chk("stat_stalls", 32'(stat_stalls), 32'(e.n_st));
          chk("stat_fwd_exmem", 32'(stat_fwd_exmem), 32'(e.n_em));
          chk("stat_fwd_memwb", 32'(stat_fwd_memwb), 32'(e.n_mw));
`endif
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cycle=%0d actual=timeout expected=finish", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    int rs, rt, dest;
    bit v, rw, mr, fl, r;
    // reset, then directed programs (args: rst, valid, rs, rt, dest, regwrite, memread, flush)
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 1, 2, 3, 1, 0, 0);   // add $3,$1,$2
    drive(0, 1, 3, 5, 4, 1, 0, 0);   // sub $4,$3,$5 -> A=01
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 1, 2, 3, 1, 0, 0);   // add $3
    drive(0, 0, 0, 0, 0, 0, 0, 0);   // nop
    drive(0, 1, 7, 3, 6, 1, 0, 0);   // or $6,$7,$3 -> B=10
    drive(0, 1, 1, 2, 3, 1, 0, 0);   // add $3
    drive(0, 1, 4, 5, 3, 1, 0, 0);   // add $3
    drive(0, 1, 3, 3, 8, 1, 0, 0);   // and $8,$3,$3 -> both 01
    drive(0, 1, 1, 0, 9, 1, 1, 0);   // lw $9
    drive(0, 1, 9, 9, 10, 1, 0, 0);  // add $10,$9,$9 -> stall
    drive(0, 1, 9, 9, 10, 1, 0, 0);  // re-issued -> both 10
    drive(0, 1, 1, 2, 0, 1, 0, 0);   // add $0
    drive(0, 1, 0, 0, 11, 1, 0, 0);  // use $0 -> 00
    drive(0, 1, 1, 0, 9, 1, 1, 0);   // lw $9
    drive(0, 1, 9, 2, 12, 1, 0, 1);  // use with flush -> no stall, bubble
    drive(0, 1, 9, 2, 12, 1, 0, 0);
    drive(0, 1, 1, 0, 9, 1, 1, 0);   // lw $9
    drive(1, 1, 9, 9, 10, 1, 0, 0);  // reset during the stall cycle
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 9, 9, 10, 1, 0, 0);
    // random traffic on a small register window to provoke hazards
    for (int i = 0; i < 400; i++) begin
      if (!last_stall) begin
        r    = ($urandom_range(0, 99) < 2);
        v    = ($urandom_range(0, 99) < 88);
        rs   = $urandom_range(0, 7);
        rt   = $urandom_range(0, 7);
        dest = $urandom_range(0, 7);
        rw   = ($urandom_range(0, 99) < 75);
        mr   = ($urandom_range(0, 99) < 30);
        fl   = ($urandom_range(0, 99) < 8);
      end else begin
        r  = 1'b0;
        fl = ($urandom_range(0, 99) < 8);
      end
      drive(r, v, rs, rt, dest, rw, mr, fl);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
